// File: rtl/atpg_pkg.sv
// atpg_pkg: FSM states, MISR polynomial selection and masked-compare helper for atpg_vector_engine.
package atpg_pkg;
   typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CAPT, FIN} st_e;
   localparam int MAX_W = 64;
   localparam logic [MAX_W-1:0] MISR_POLY_22 = 64'h200001;
   // Widths without a tabulated polynomial fall back to x^(w-1) + 1.
   function automatic logic [MAX_W-1:0] misr_poly(input int w);
      return w == 22 ? MISR_POLY_22 : (MAX_W'(1) << (w - 1)) | MAX_W'(1);
   endfunction
   function automatic logic mask_fail(input logic [MAX_W-1:0] resp, input logic [MAX_W-1:0] exp,
                                      input logic [MAX_W-1:0] mask);
      return |((resp ^ exp) & mask);
   endfunction
endpackage

// File: rtl/atpg_pattern_mem.sv
// atpg_pattern_mem: vector/expected/mask slot array, synchronous write and combinational read.
module atpg_pattern_mem #(
   parameter int DEPTH = 16,
   parameter int W = 94,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [W-1:0]     wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [W-1:0]     rdata
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/atpg_vector_engine.sv
// atpg_vector_engine: applies stored vectors to a CUT, captures and masked-compares responses.
// Define ATPG_MISR_EN to add the misr_sig response signature output.
module atpg_vector_engine
   import atpg_pkg::*;
#(
   parameter int IN_W = 50,
   parameter int OUT_W = 22,
   parameter int DEPTH = 16,
   parameter int SETTLE = 1,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_addr,
   input  logic [IN_W-1:0]  cfg_vec,
   input  logic [OUT_W-1:0] cfg_exp,
   input  logic [OUT_W-1:0] cfg_mask,
   input  logic             start,
   input  logic [IDX_W:0]   num_vec,
   output logic             busy,
   output logic             done,
   output logic [IN_W-1:0]  dut_in,
   input  logic [OUT_W-1:0] dut_out,
   output logic             cap_valid,
   output logic [IDX_W-1:0] cap_idx,
   output logic [OUT_W-1:0] cap_resp,
   output logic             cap_fail,
   output logic [IDX_W:0]   fail_cnt,
   output logic             first_fail_vld,
   output logic [IDX_W-1:0] first_fail_idx
`ifdef ATPG_MISR_EN
   ,
   output logic [OUT_W-1:0] misr_sig
`endif
);
   localparam int MW = IN_W + 2 * OUT_W;
   localparam int CW = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] WINIT = CW'(SETTLE - 1);
   localparam logic [IDX_W:0] DMAX = (IDX_W + 1)'(DEPTH);
`ifdef ATPG_MISR_EN
   localparam logic [OUT_W-1:0] POLY = OUT_W'(misr_poly(OUT_W));
`endif
   st_e st, st_n;
   logic [IDX_W-1:0] idx;
   logic [IDX_W:0] nv;
   logic [CW-1:0] wcnt;
   logic [MW-1:0] rd;
   logic [IN_W-1:0] r_vec;
   logic [OUT_W-1:0] r_exp, r_mask;
   logic acc, last, miss;
   assign acc = st == IDLE && start;
   assign busy = st inside {DRIVE, WAIT, CAPT};
   atpg_pattern_mem #(.DEPTH(DEPTH), .W(MW), .IDX_W(IDX_W)) u_mem (
      .clk  (clk),
      .we   (cfg_we && st == IDLE),
      .waddr(cfg_addr),
      .wdata({cfg_vec, cfg_exp, cfg_mask}),
      .raddr(idx),
      .rdata(rd)
   );
   assign {r_vec, r_exp, r_mask} = rd;
   assign miss = mask_fail(MAX_W'(dut_out), MAX_W'(r_exp), MAX_W'(r_mask));
   assign last = {1'b0, idx} == nv - 1'b1;
   always_comb begin
      st_n = st;
      case (st)
         IDLE:    st_n = start ? (num_vec == '0 ? FIN : DRIVE) : IDLE;
         DRIVE:   st_n = SETTLE > 1 ? WAIT : CAPT;
         WAIT:    st_n = wcnt == CW'(1) ? CAPT : WAIT;
         CAPT:    st_n = last ? FIN : DRIVE;
         default: st_n = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         st <= IDLE;
         idx <= '0;
         nv <= '0;
         wcnt <= '0;
         dut_in <= '0;
         done <= 1'b0;
         cap_valid <= 1'b0;
         cap_idx <= '0;
         cap_resp <= '0;
         cap_fail <= 1'b0;
         fail_cnt <= '0;
         first_fail_vld <= 1'b0;
         first_fail_idx <= '0;
`ifdef ATPG_MISR_EN
         misr_sig <= '0;
`endif
      end else begin
         st <= st_n;
         done <= st == FIN;
         cap_valid <= st == CAPT;
         if (acc) begin
            nv <= num_vec > DMAX ? DMAX : num_vec;
            idx <= '0;
            fail_cnt <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
`ifdef ATPG_MISR_EN
            misr_sig <= '0;
`endif
         end
         if (st == DRIVE) begin
            dut_in <= r_vec;
            wcnt <= WINIT;
         end
         if (st == WAIT) wcnt <= wcnt - 1'b1;
         if (st == CAPT) begin
            cap_idx <= idx;
            cap_resp <= dut_out;
            cap_fail <= miss;
            if (miss) fail_cnt <= fail_cnt + 1'b1;
            if (miss && !first_fail_vld) begin
               first_fail_vld <= 1'b1;
               first_fail_idx <= idx;
            end
            if (!last) idx <= idx + 1'b1;
`ifdef ATPG_MISR_EN
            misr_sig <= {misr_sig[OUT_W-2:0], ^(misr_sig & POLY)} ^ dut_out;
`endif
         end
      end
endmodule

// File: tb/tb_atpg_vector_engine.sv
// tb_atpg_vector_engine: directed + random runs on a SETTLE=1 and a SETTLE=4 engine against a run-level model.
module tb_atpg_vector_engine;
   logic clk = 0, rst = 1;
   logic cfg_we[2], start[2];
   logic [3:0] cfg_addr;
   logic [49:0] cfg_vec;
   logic [21:0] cfg_exp, cfg_mask, inj;
   logic [4:0] num_vec;
   logic busy[2], done[2], cap_valid[2], cap_fail[2], first_fail_vld[2];
   logic [49:0] dut_in[2];
   logic [21:0] dut_out[2], cap_resp[2];
   logic [3:0] cap_idx[2], first_fail_idx[2];
   logic [4:0] fail_cnt[2];
`ifdef ATPG_MISR_EN
   logic [21:0] misr_sig[2];
   logic [21:0] saved_sig;
   localparam logic [21:0] POLY = 22'h200001;
`endif
   logic [49:0] mv[2][16];
   logic [21:0] me[2][16], mm[2][16];
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   function automatic logic [21:0] cut(input logic [49:0] x);
      return x[21:0] ^ x[43:22] ^ {x[49:44], x[15:0]} ^ ({x[10:0], x[21:11]} & x[43:22]);
   endfunction
   function automatic logic [49:0] rnd50();
      return {18'($urandom), $urandom};
   endfunction

   assign dut_out[0] = cut(dut_in[0]) ^ inj;
   assign dut_out[1] = cut(dut_in[1]);

   atpg_vector_engine #(.SETTLE(1)) u0 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we[0]), .cfg_addr(cfg_addr), .cfg_vec(cfg_vec),
      .cfg_exp(cfg_exp), .cfg_mask(cfg_mask), .start(start[0]), .num_vec(num_vec),
      .busy(busy[0]), .done(done[0]), .dut_in(dut_in[0]), .dut_out(dut_out[0]),
      .cap_valid(cap_valid[0]), .cap_idx(cap_idx[0]), .cap_resp(cap_resp[0]),
      .cap_fail(cap_fail[0]), .fail_cnt(fail_cnt[0]), .first_fail_vld(first_fail_vld[0]),
      .first_fail_idx(first_fail_idx[0])
`ifdef ATPG_MISR_EN
      , .misr_sig(misr_sig[0])
`endif
   );
   atpg_vector_engine #(.SETTLE(4)) u1 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we[1]), .cfg_addr(cfg_addr), .cfg_vec(cfg_vec),
      .cfg_exp(cfg_exp), .cfg_mask(cfg_mask), .start(start[1]), .num_vec(num_vec),
      .busy(busy[1]), .done(done[1]), .dut_in(dut_in[1]), .dut_out(dut_out[1]),
      .cap_valid(cap_valid[1]), .cap_idx(cap_idx[1]), .cap_resp(cap_resp[1]),
      .cap_fail(cap_fail[1]), .fail_cnt(fail_cnt[1]), .first_fail_vld(first_fail_vld[1]),
      .first_fail_idx(first_fail_idx[1])
`ifdef ATPG_MISR_EN
      , .misr_sig(misr_sig[1])
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load(input int u, input int a, input logic [49:0] v, input logic [21:0] e,
                       input logic [21:0] m);
      cfg_we[u] = 1; cfg_addr = 4'(a); cfg_vec = v; cfg_exp = e; cfg_mask = m;
      mv[u][a] = v; me[u][a] = e; mm[u][a] = m;
      @(posedge clk); #1;
      cfg_we[u] = 0;
   endtask

   // Expected behaviour per accepted start: capture k appears (S+1)(k+1) cycles
   // after the start edge, done one cycle after the last capture.
   task automatic run(input int u, input int n, input bit disturb, input bit wr);
      int s, ne, len, fc, fi, k;
      bit fv, f;
      logic [21:0] resp, sig;
      logic [49:0] v;
      s = u ? 4 : 1; ne = n > 16 ? 16 : n; len = ne * (s + 1);
      fc = 0; fi = 0; fv = 0; sig = '0;
      num_vec = 5'(n);
      if (wr) begin
         v = rnd50();
         cfg_we[u] = 1; cfg_addr = 0; cfg_vec = v; cfg_exp = cut(v); cfg_mask = '1;
         mv[u][0] = v; me[u][0] = cut(v); mm[u][0] = '1;
      end
      start[u] = 1;
      @(posedge clk); #1;
      start[u] = 0; cfg_we[u] = 0;
      for (int c = 0; c <= len + 1; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (disturb && c == 1) begin
            start[u] = 1; cfg_we[u] = 1; cfg_addr = 0; cfg_vec = ~mv[u][0];
         end
         if (disturb && c == 2) begin start[u] = 0; cfg_we[u] = 0; end
         chk("busy", 64'(busy[u]), 64'(c < len));
         chk("done", 64'(done[u]), 64'(c == len + 1));
         f = c > 0 && c <= len && c % (s + 1) == 0;
         chk("cap_valid", 64'(cap_valid[u]), 64'(f));
         if (c >= 1 && c <= len) chk("dut_in", 64'(dut_in[u]), 64'(mv[u][(c - 1) / (s + 1)]));
         if (f) begin
            k = c / (s + 1) - 1;
            resp = cut(mv[u][k]) ^ (u == 0 ? inj : 22'h0);
            f = |((resp ^ me[u][k]) & mm[u][k]);
            chk("cap_idx", 64'(cap_idx[u]), 64'(k));
            chk("cap_resp", 64'(cap_resp[u]), 64'(resp));
            chk("cap_fail", 64'(cap_fail[u]), 64'(f));
            if (f) begin
               fc++;
               if (!fv) begin fv = 1; fi = k; end
            end
`ifdef ATPG_MISR_EN
            sig = {sig[20:0], ^(sig & POLY)} ^ resp;
`endif
         end
      end
      chk("fail_cnt", 64'(fail_cnt[u]), 64'(fc));
      chk("first_fail_vld", 64'(first_fail_vld[u]), 64'(fv));
      chk("first_fail_idx", 64'(first_fail_idx[u]), 64'(fi));
`ifdef ATPG_MISR_EN
      chk("misr_sig", 64'(misr_sig[u]), 64'(sig));
`endif
   endtask

   initial begin
      logic [49:0] v;
      logic [21:0] e;
      cfg_we[0] = 0; cfg_we[1] = 0; start[0] = 0; start[1] = 0;
      cfg_addr = 0; cfg_vec = 0; cfg_exp = 0; cfg_mask = 0; num_vec = 0; inj = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         chk("rst_busy", 64'(busy[u]), 0);
         chk("rst_done", 64'(done[u]), 0);
         chk("rst_dut_in", 64'(dut_in[u]), 0);
         chk("rst_cap_valid", 64'(cap_valid[u]), 0);
         chk("rst_fail_cnt", 64'(fail_cnt[u]), 0);
         chk("rst_ffv", 64'(first_fail_vld[u]), 0);
      end
      rst = 0;
      for (int a = 0; a < 3; a++) begin v = rnd50(); load(0, a, v, cut(v), '1); end
      run(0, 3, 0, 0);
      load(0, 1, mv[0][1], me[0][1] ^ 22'h1, '1);
      run(0, 3, 0, 0);
      chk("plan_fail_cnt", 64'(fail_cnt[0]), 1);
      chk("plan_first_idx", 64'(first_fail_idx[0]), 1);
      run(0, 0, 0, 0);
      load(0, 1, mv[0][1], me[0][1], 22'h3ffffe);
      run(0, 3, 0, 0);
      chk("plan_masked_cnt", 64'(fail_cnt[0]), 0);
      run(0, 2, 1, 0);
      run(0, 1, 0, 0);
      run(0, 2, 0, 1);
      num_vec = 3; start[0] = 1;
      @(posedge clk); #1;
      start[0] = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("midrst_busy", 64'(busy[0]), 0);
      chk("midrst_dut_in", 64'(dut_in[0]), 0);
      chk("midrst_fail_cnt", 64'(fail_cnt[0]), 0);
      chk("midrst_cap_valid", 64'(cap_valid[0]), 0);
      for (int i = 0; i < 3; i++) begin
         chk("midrst_done", 64'(done[0]), 0);
         @(posedge clk); #1;
      end
      run(0, 3, 0, 0);
      for (int a = 0; a < 16; a++) begin
         v = rnd50();
         e = cut(v) ^ ($urandom_range(0, 2) == 0 ? 22'(1) << $urandom_range(0, 21) : 22'h0);
         load(0, a, v, e, 22'($urandom));
      end
      run(0, 20, 0, 0);
      run(0, 16, 0, 0);
`ifdef ATPG_MISR_EN
      run(0, 3, 0, 0);
      saved_sig = misr_sig[0];
      run(0, 3, 0, 0);
      chk("misr_repeat", 64'(misr_sig[0]), 64'(saved_sig));
      inj = 22'h400;
      run(0, 3, 0, 0);
      chk("misr_differs", 64'(misr_sig[0] != saved_sig), 1);
      inj = 0;
`endif
      for (int a = 0; a < 2; a++) begin v = rnd50(); load(1, a, v, cut(v), '1); end
      run(1, 2, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
